student_tlul_arb: RTL



---
 rtl/tlul_pkg.sv | 34 +++
 rtl/student_tlul_arb.sv | 126 ++++++++++++
 2 files changed

// File: rtl/tlul_pkg.sv
// TL-UL channel bundles shared by the arbiter and its neighbours.
// Field set is the 32-bit TL-UL subset used on this bus.
package tlul_pkg;

    localparam logic [2:0] PUT_FULL_DATA   = 3'd0;
    localparam logic [2:0] GET             = 3'd4;
    localparam logic [2:0] ACCESS_ACK      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/student_tlul_arb.sv
// N-host to 1-device TL-UL arbiter: round-robin A grant, in-order D return via a host-index FIFO.
// Latency: zero cycles both directions; A/D data paths are purely combinational.
// Backpressure: a_ready only to the granted host, withheld when tracking FIFO is full; define
// STUDENT_TLUL_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module student_tlul_arb #(
    parameter int NUM   = 2,
    parameter int DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  tlul_pkg::tl_h2d_t tl_host_i [NUM],
    output tlul_pkg::tl_d2h_t tl_host_o [NUM],
    output tlul_pkg::tl_h2d_t tl_device_o,
    input  tlul_pkg::tl_d2h_t tl_device_i
);

    localparam int IW = $clog2(NUM);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [IW-1:0] r_rr_ptr;
    logic          r_lock;
    logic [IW-1:0] r_lock_idx;
    logic [IW-1:0] r_fifo [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic [IW-1:0] w_search;
    logic          w_found;
    logic [IW-1:0] w_grant;
    logic          w_gnt_vld;
    logic [IW-1:0] w_head;
    logic [IW-1:0] w_next_rr;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // In fixed-priority builds r_rr_ptr is pinned at 0, so the search always starts at host 0.
    always_comb begin
        w_search = r_rr_ptr;
        w_found  = 1'b0;
        for (int i = 0; i < NUM; i++) begin
            if (!w_found && tl_host_i[IW'((int'(r_rr_ptr) + i) % NUM)].a_valid) begin
                w_found  = 1'b1;
                w_search = IW'((int'(r_rr_ptr) + i) % NUM);
            end
        end
    end

    assign w_grant   = r_lock ? r_lock_idx : w_search;
    assign w_gnt_vld = tl_host_i[w_grant].a_valid;
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_head    = r_fifo[r_rd_ptr];

`ifdef STUDENT_TLUL_ARB_FIXED_PRIO_EN
    assign w_next_rr = '0;
`else
    assign w_next_rr = (w_grant == IW'(NUM - 1)) ? '0 : w_grant + 1'b1;
`endif

    always_comb begin
        tl_device_o         = tl_host_i[w_grant];
        tl_device_o.a_valid = rst_ni && w_gnt_vld && !w_full;
        tl_device_o.d_ready = rst_ni && !w_empty && tl_host_i[w_head].d_ready;
        for (int i = 0; i < NUM; i++) begin
            tl_host_o[i]         = tl_device_i;
            tl_host_o[i].d_valid = rst_ni && !w_empty && (w_head == IW'(i)) && tl_device_i.d_valid;
            tl_host_o[i].a_ready = rst_ni && !w_full && (w_grant == IW'(i)) && tl_device_i.a_ready;
        end
    end

    assign w_push = tl_device_o.a_valid && tl_device_i.a_ready;
    assign w_pop  = tl_device_i.d_valid && tl_device_o.d_ready;

    // A presented-but-stalled beat pins the grant so the A channel stays stable until accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr   <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_rr_ptr <= w_next_rr;
                r_lock   <= 1'b0;
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end else if (w_gnt_vld) begin
                r_lock     <= 1'b1;
                r_lock_idx <= w_grant;
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_grant;
        end
    end

`ifndef SYNTHESIS
    // A response with nothing outstanding has no owner; it is left unacknowledged.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(tl_device_i.d_valid && w_empty));
        end
    end
`endif

endmodule
